// File: rtl/pipe_pkg.sv
// +-----------------------------------------------------------------------------+
// | pipe_pkg                                                                    |
// | Shared RV32I pipeline encodings: load/store/branch kinds and MEM FSM states.|
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

package pipe_pkg;

   localparam logic [2:0] LOAD_NONE = 3'd0;
   localparam logic [2:0] LOAD_LB   = 3'd1;
   localparam logic [2:0] LOAD_LH   = 3'd2;
   localparam logic [2:0] LOAD_LW   = 3'd3;
   localparam logic [2:0] LOAD_LBU  = 3'd4;
   localparam logic [2:0] LOAD_LHU  = 3'd5;

   localparam logic [1:0] STORE_NONE = 2'd0;
   localparam logic [1:0] STORE_SB   = 2'd1;
   localparam logic [1:0] STORE_SH   = 2'd2;
   localparam logic [1:0] STORE_SW   = 2'd3;

   localparam logic [2:0] BR_NONE = 3'd0;
   localparam logic [2:0] BR_JAL  = 3'd1;
   localparam logic [2:0] BR_JALR = 3'd2;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } size_t;

   // Access width of a memory op; only one of ld/st is ever nonzero.
   function automatic size_t access_size(input logic [2:0] ld, input logic [1:0] st);
      size_t sz;
      sz = SIZE_WORD;
      if (ld == LOAD_LB || ld == LOAD_LBU || st == STORE_SB)
         sz = SIZE_BYTE;
      else if (ld == LOAD_LH || ld == LOAD_LHU || st == STORE_SH)
         sz = SIZE_HALF;
      return sz;
   endfunction

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
// +-----------------------------------------------------------------------------+
// | load_extend                                                                 |
// | Selects the byte/half lane of a read word and sign- or zero-extends it.     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module load_extend
   import pipe_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  load_type,
   output logic [31:0] data
);

   logic [31:0] w_shifted;

   assign w_shifted = rdata >> {offset, 3'b000};

   always_comb begin
      data = rdata;
      case (load_type)
         LOAD_LB:  data = {{24{w_shifted[7]}}, w_shifted[7:0]};
         LOAD_LBU: data = {24'd0, w_shifted[7:0]};
         LOAD_LH:  data = {{16{w_shifted[15]}}, w_shifted[15:0]};
         LOAD_LHU: data = {16'd0, w_shifted[15:0]};
         default:  data = rdata;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// +-----------------------------------------------------------------------------+
// | mem_access                                                                  |
// | RV32I memory stage: req/ack data-memory loads/stores and write-back bundle. |
// | Optional macro MISALIGN_TRAP_EN: trap misaligned half/word accesses.        |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module mem_access
   import pipe_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [XLEN-1:0]   alu_result,
   input  logic [XLEN-1:0]   notbranch_pc,
   input  logic [XLEN-1:0]   rs2E,
   input  logic              write_regE,
   input  logic [2:0]        info_loadE,
   input  logic [1:0]        info_storeE,
   input  logic [2:0]        info_branchE,
   input  logic [4:0]        dstreg_addrE,
   output logic              stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [3:0]        dmem_be,
   output logic [XLEN-1:0]   dmem_wdata,
   input  logic [XLEN-1:0]   dmem_rdata,
   input  logic              dmem_ack,
   output logic              wb_valid,
   output logic              wb_en,
   output logic [4:0]        wb_addr,
   output logic [XLEN-1:0]   wb_data,
   output logic              misalign_err
);

   state_t            r_state;
   state_t            w_next_state;
   logic              w_mem_op;
   logic              w_trap;
   logic              w_issue;
   size_t             w_size;
   logic [1:0]        w_raw_off;
   logic [1:0]        w_off;
   logic [3:0]        w_be;
   logic [XLEN-1:0]   w_wdata;
   logic [XLEN-1:0]   w_load_data;
   logic [2:0]        r_load_type;
   logic [1:0]        r_off;
   logic [4:0]        r_rd;
   logic              r_write_reg;

   assign w_mem_op  = in_valid && (info_loadE != LOAD_NONE || info_storeE != STORE_NONE);
   assign w_size    = access_size(info_loadE, info_storeE);
   assign w_raw_off = alu_result[1:0];
   assign w_issue   = w_mem_op && !w_trap;

`ifdef MISALIGN_TRAP_EN
   assign w_trap = w_mem_op && ((w_size == SIZE_HALF && w_raw_off[0]) ||
                                (w_size == SIZE_WORD && w_raw_off != 2'b00));
   assign w_off  = w_raw_off;
`else
   assign w_trap = 1'b0;
   // Misaligned offsets are silently rounded down to the access's natural alignment.
   always_comb begin
      w_off = w_raw_off;
      case (w_size)
         SIZE_HALF: w_off = {w_raw_off[1], 1'b0};
         SIZE_WORD: w_off = 2'b00;
         default:   w_off = w_raw_off;
      endcase
   end
`endif

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = rs2E;
      case (w_size)
         SIZE_BYTE: begin
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{rs2E[7:0]}};
         end
         SIZE_HALF: begin
            w_be    = 4'b0011 << w_off;
            w_wdata = {2{rs2E[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = rs2E;
         end
      endcase
   end

   load_extend u_load_extend (
      .rdata     (dmem_rdata),
      .offset    (r_off),
      .load_type (r_load_type),
      .data      (w_load_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      stall        = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_issue) begin
               w_next_state = WAIT;
               stall        = 1'b1;
            end
         end
         WAIT: begin
            stall = !dmem_ack;
            if (dmem_ack)
               w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
      if (!rst_n)
         stall = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dmem_req    <= 1'b0;
         dmem_we     <= 1'b0;
         dmem_addr   <= '0;
         dmem_be     <= 4'd0;
         dmem_wdata  <= '0;
         wb_valid    <= 1'b0;
         wb_en       <= 1'b0;
         wb_addr     <= 5'd0;
         wb_data     <= '0;
         r_load_type <= LOAD_NONE;
         r_off       <= 2'd0;
         r_rd        <= 5'd0;
         r_write_reg <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_issue) begin
                  dmem_req    <= 1'b1;
                  dmem_we     <= (info_storeE != STORE_NONE);
                  dmem_addr   <= {alu_result[ADDR_W-1:2], 2'b00};
                  dmem_be     <= w_be;
                  dmem_wdata  <= w_wdata;
                  r_load_type <= info_loadE;
                  r_off       <= w_off;
                  r_rd        <= dstreg_addrE;
                  r_write_reg <= write_regE;
                  wb_valid    <= 1'b0;
                  wb_en       <= 1'b0;
               end else begin
                  // Trapped accesses still retire a (non-writing) bundle.
                  wb_valid <= in_valid;
                  wb_en    <= in_valid && write_regE && (dstreg_addrE != 5'd0) && !w_trap;
                  wb_addr  <= dstreg_addrE;
                  if (w_trap)
                     wb_data <= '0;
                  else if (info_branchE == BR_JAL || info_branchE == BR_JALR)
                     wb_data <= notbranch_pc;
                  else
                     wb_data <= alu_result;
               end
            end
            WAIT: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  wb_valid <= 1'b1;
                  wb_en    <= (r_load_type != LOAD_NONE) && r_write_reg && (r_rd != 5'd0);
                  wb_addr  <= r_rd;
                  wb_data  <= (r_load_type != LOAD_NONE) ? w_load_data : '0;
               end else begin
                  wb_valid <= 1'b0;
                  wb_en    <= 1'b0;
               end
            end
            default: begin
               dmem_req <= 1'b0;
               wb_valid <= 1'b0;
               wb_en    <= 1'b0;
            end
         endcase
      end
   end

`ifdef MISALIGN_TRAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         misalign_err <= 1'b0;
      else
         misalign_err <= (r_state == IDLE) && w_trap;
   end
`else
   assign misalign_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// +-----------------------------------------------------------------------------+
// | tb_mem_access                                                               |
// | Self-checking bench for mem_access: directed cases plus random op stream.   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] alu_result, notbranch_pc, rs2E;
   logic        write_regE;
   logic [2:0]  info_loadE, info_branchE;
   logic [1:0]  info_storeE;
   logic [4:0]  dstreg_addrE;
   logic        stall, dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        wb_valid, wb_en, misalign_err;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   int n_tests = 0;
   int n_fail  = 0;

   mem_access #(.XLEN(32), .ADDR_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .alu_result   (alu_result),
      .notbranch_pc (notbranch_pc),
      .rs2E         (rs2E),
      .write_regE   (write_regE),
      .info_loadE   (info_loadE),
      .info_storeE  (info_storeE),
      .info_branchE (info_branchE),
      .dstreg_addrE (dstreg_addrE),
      .stall        (stall),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_be      (dmem_be),
      .dmem_wdata   (dmem_wdata),
      .dmem_rdata   (dmem_rdata),
      .dmem_ack     (dmem_ack),
      .wb_valid     (wb_valid),
      .wb_en        (wb_en),
      .wb_addr      (wb_addr),
      .wb_data      (wb_data),
      .misalign_err (misalign_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: bytes touched by an op
   function automatic int nbytes(input logic [2:0] ld, input logic [1:0] st);
      if (ld == 3'd1 || ld == 3'd4 || st == 2'd1) return 1;
      if (ld == 3'd2 || ld == 3'd5 || st == 2'd2) return 2;
      return 4;
   endfunction

   function automatic int eff_off(input int n, input int a);
`ifdef MISALIGN_TRAP_EN
      return a;
`else
      return a - (a % n);
`endif
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] ld, input logic [31:0] rdata, input int off);
      logic [31:0] v;
      v = rdata >> (8 * off);
      if (ld == 3'd1 || ld == 3'd4) begin
         v = v & 32'hFF;
         if (ld == 3'd1 && v >= 32'd128) v = v + 32'hFFFFFF00;
      end else if (ld == 3'd2 || ld == 3'd5) begin
         v = v & 32'hFFFF;
         if (ld == 3'd2 && v >= 32'd32768) v = v + 32'hFFFF0000;
      end
      return v;
   endfunction

   // Drives one bundle starting at a negedge and checks its whole life, ending
   // at the negedge where its write-back bundle is visible.
   task automatic run_op(input logic v, input logic [2:0] ld, input logic [1:0] st,
                         input logic [2:0] br, input logic [31:0] addr, input logic [31:0] pc,
                         input logic [31:0] rs2, input logic [31:0] rdata, input logic wr,
                         input logic [4:0] rd, input int dly, input logic ack_idle);
      logic        mem, trap;
      int          n, a, off;
      logic [31:0] e_be, e_wd;
      in_valid = v; info_loadE = ld; info_storeE = st; info_branchE = br;
      alu_result = addr; notbranch_pc = pc; rs2E = rs2; write_regE = wr;
      dstreg_addrE = rd; dmem_ack = ack_idle; dmem_rdata = $urandom;
      mem  = v && (ld != 3'd0 || st != 2'd0);
      n    = nbytes(ld, st);
      a    = int'(addr[1:0]);
`ifdef MISALIGN_TRAP_EN
      trap = mem && ((a % n) != 0);
`else
      trap = 1'b0;
`endif
      off  = eff_off(n, a);
      e_be = ((32'd1 << n) - 32'd1) << off;
      e_wd = (n == 1) ? rs2[7:0] * 32'h01010101 : (n == 2) ? rs2[15:0] * 32'h00010001 : rs2;
      #1;
      check("stall_accept", {31'd0, stall}, {31'd0, mem && !trap});
      @(posedge clk); @(negedge clk);
      dmem_ack = 1'b0;
      if (mem && !trap) begin
         check("req", {31'd0, dmem_req}, 32'd1);
         check("we", {31'd0, dmem_we}, {31'd0, st != 2'd0});
         check("addr", dmem_addr, addr & 32'hFFFFFFFC);
         check("be", {28'd0, dmem_be}, e_be);
         if (st != 2'd0) check("wdata", dmem_wdata, e_wd);
         for (int k = 0; k <= dly; k++) begin
            if (k == dly) begin dmem_ack = 1'b1; dmem_rdata = rdata; end
            #1;
            check("stall_wait", {31'd0, stall}, {31'd0, k != dly});
            check("req_hold", {31'd0, dmem_req}, 32'd1);
            check("wb_valid_wait", {31'd0, wb_valid}, 32'd0);
            @(posedge clk); @(negedge clk);
         end
         dmem_ack = 1'b0;
         check("req_drop", {31'd0, dmem_req}, 32'd0);
         check("wb_valid_mem", {31'd0, wb_valid}, 32'd1);
         check("wb_en_mem", {31'd0, wb_en}, {31'd0, ld != 3'd0 && wr && rd != 5'd0});
         if (ld != 3'd0) begin
            check("wb_addr_ld", {27'd0, wb_addr}, {27'd0, rd});
            check("wb_data_ld", wb_data, exp_load(ld, rdata, off));
         end
      end else begin
         check("no_req", {31'd0, dmem_req}, 32'd0);
         check("wb_valid", {31'd0, wb_valid}, {31'd0, v});
         check("wb_en", {31'd0, wb_en}, {31'd0, v && wr && rd != 5'd0 && !trap});
         if (v && !trap) begin
            check("wb_addr", {27'd0, wb_addr}, {27'd0, rd});
            check("wb_data", wb_data, (br == 3'd1 || br == 3'd2) ? pc : addr);
         end
      end
      check("misalign_err", {31'd0, misalign_err}, {31'd0, trap});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; alu_result = '0; notbranch_pc = '0; rs2E = '0;
      write_regE = 1'b0; info_loadE = '0; info_storeE = '0; info_branchE = '0;
      dstreg_addrE = '0; dmem_ack = 1'b0; dmem_rdata = '0;
      repeat (2) @(negedge clk);
      check("rst_req", {31'd0, dmem_req}, 32'd0);
      check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("rst_wb_data", wb_data, 32'd0);
      check("rst_addr", dmem_addr, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      rst_n = 1'b1;

      // Directed cases
      run_op(1, 0, 0, 0, 32'h1234, 32'h4, 32'h0, 32'h0, 1, 5, 0, 0);
      run_op(1, 0, 0, 1, 32'h9999, 32'h108, 32'h0, 32'h0, 1, 1, 0, 0);
      run_op(1, 0, 0, 1, 32'h9999, 32'h108, 32'h0, 32'h0, 1, 0, 0, 1);
      run_op(1, 0, 1, 0, 32'h102, 32'h0, 32'hAB, 32'h0, 0, 3, 3, 0);
      run_op(1, 1, 0, 0, 32'h103, 32'h0, 32'h0, 32'h80000000, 1, 7, 0, 0);
      run_op(1, 4, 0, 0, 32'h103, 32'h0, 32'h0, 32'h80000000, 1, 7, 1, 0);
      run_op(1, 2, 0, 0, 32'h102, 32'h0, 32'h0, 32'h80011234, 1, 8, 2, 0);
      run_op(1, 3, 0, 0, 32'h101, 32'h0, 32'h0, 32'hCAFEF00D, 1, 9, 0, 0);
      run_op(0, 3, 0, 0, 32'h200, 32'h0, 32'h0, 32'h0, 1, 9, 0, 1);

      // Reset abandons an outstanding request
      in_valid = 1'b1; info_loadE = 3'd3; info_storeE = 2'd0; alu_result = 32'h300;
      write_regE = 1'b1; dstreg_addrE = 5'd4;
      @(posedge clk); @(negedge clk);
      check("pre_rst_req", {31'd0, dmem_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_req", {31'd0, dmem_req}, 32'd0);
      check("mid_rst_stall", {31'd0, stall}, 32'd0);
      check("mid_rst_wb", {31'd0, wb_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      check("post_rst_wb", {31'd0, wb_valid}, 32'd0);
      check("post_rst_req", {31'd0, dmem_req}, 32'd0);
      run_op(1, 3, 0, 0, 32'h300, 32'h0, 32'h0, 32'h11223344, 1, 4, 0, 0);

      // Random stream
      for (int i = 0; i < 200; i++) begin
         int          kind;
         logic [2:0]  ld, br;
         logic [1:0]  st;
         logic [4:0]  rd;
         kind = $urandom_range(0, 3);
         ld = 3'd0; st = 2'd0;
         if (kind == 1 || kind == 3) ld = 3'($urandom_range(1, 5));
         if (kind == 2) st = 2'($urandom_range(1, 3));
         br = 3'($urandom_range(0, 7));
         rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         run_op(kind != 3, ld, st, br, $urandom, $urandom, $urandom, $urandom,
                1'($urandom_range(0, 1)), rd, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_access.md
Name: mem_access

Overview:
Memory-access stage directly downstream of the execute stage in the 5-stage RV32I pipeline. It consumes the registered ALU result, store data and control fields, and performs loads and stores over a req/ack data-memory handshake. Loaded data is sign- or zero-extended here. It stalls upstream while an access is outstanding and produces the registered write-back bundle for the register-file stage.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
ADDR_W, 32, data-memory address width; dmem_addr carries the low ADDR_W bits.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  execute bundle valid; 0 = bubble
alu_result  in  32  effective address, or non-memory result
notbranch_pc  in  32  pc+4, the link value
rs2E  in  32  store data
write_regE  in  1  instruction writes rd
info_loadE  in  3  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU
info_storeE  in  2  0 none, 1 SB, 2 SH, 3 SW
info_branchE  in  3  0 none, 1 JAL, 2 JALR, 3-7 conditional
dstreg_addrE  in  5  rd index
stall  out  1  upstream must hold its bundle
dmem_req  out  1  access request
dmem_we  out  1  1 = store
dmem_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-shifted store data
dmem_rdata  in  32  read word, valid when dmem_ack = 1
dmem_ack  in  1  access complete
wb_valid  out  1  write-back bundle valid
wb_en  out  1  register-file write enable
wb_addr  out  5  rd index
wb_data  out  32  write-back value
misalign_err  out  1  misaligned-access pulse (MISALIGN_TRAP_EN only)

Behaviour:
- Reset (async, rst_n = 0): state IDLE; all outputs 0, including dmem_* , wb_* , stall and misalign_err.
- A memory op is in_valid with info_loadE != 0 or info_storeE != 0. info_loadE and info_storeE are never both nonzero.
- FSM has two states, IDLE and WAIT.
  - IDLE, non-memory op or bubble: registers the write-back bundle; latency 1 cycle.
    - wb_valid = in_valid.
    - wb_en = in_valid & write_regE & (dstreg_addrE != 0).
    - wb_data = notbranch_pc if info_branchE is 1 or 2, else alu_result.
  - IDLE, memory op:
    - stall = 1 combinationally.
    - Latches dmem_addr, dmem_we, dmem_be, dmem_wdata, the load type, rd and write_regE.
    - Sets dmem_req = 1 and moves to WAIT; wb_valid = 0 next cycle.
  - WAIT:
    - dmem_req and all dmem_* outputs are held stable.
    - stall = !dmem_ack.
    - On dmem_ack: dmem_req drops to 0 and state returns to IDLE.
    - Next cycle, wb_valid = 1. For a load, wb_data = extended data and wb_en = latched write_reg & (rd != 0). For a store, wb_en = 0.
    - The earliest ack is the first WAIT cycle, so the minimum memory-op latency is 2 cycles.
- Lane rules (a = alu_result[1:0]):
  - Byte access: be = 1<<a; wdata = {4{rs2[7:0]}}.
  - Half access: be = 0011<<a; wdata = {2{rs2[15:0]}}.
  - Word access: be = 1111; wdata = rs2.
  - Loads select byte/half from dmem_rdata at offset a*8, then sign-extend (LB, LH) or zero-extend (LBU, LHU).
- dmem_ack while in IDLE is ignored.
- In the ack cycle, stall = 0, so upstream presents the next bundle. That bundle is accepted in the same cycle only if it is not a memory op. A memory op waits one IDLE cycle, i.e. back-to-back accesses have a 1-cycle gap.
- Reset mid-WAIT: the request is abandoned, dmem_req = 0 immediately, and no write-back occurs.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a halfword access with a[0] = 1, or a word access with a != 0, issues no request and stays IDLE. The next cycle has misalign_err = 1 for one cycle, wb_valid = 1 and wb_en = 0.
- Undefined: misalign_err is tied to 0. Misaligned offsets are forced aligned: a half access uses a & 2'b10, a word access uses a = 0.

Decomposition:
- Shared package pipe_pkg: the LOAD_*, STORE_* and BR_* encodings, and the state enum IDLE/WAIT.
- One sub-module, load_extend: combinational extraction and extension of load data from (rdata, offset, load type).

Test Plan:
- ALU op, alu_result = 0x1234, rd = 5, write_regE = 1 → next cycle wb_valid = 1, wb_en = 1, wb_data = 0x1234, no dmem_req.
- JAL, notbranch_pc = 0x108, rd = 1 → wb_data = 0x108; the same op with rd = 0 → wb_en = 0.
- SB, addr = 0x102, rs2 = 0xAB → dmem_addr = 0x100, be = 0100, wdata = 0xABABABAB, we = 1; ack after 3 WAIT cycles → stall high for 4 cycles, wb_en = 0.
- LB, addr = 0x103, rdata = 0x80000000 → wb_data = 0xFFFFFF80; LBU → 0x00000080; LH at 0x102 with rdata = 0x8001xxxx → 0xFFFF8001.
- rst_n low during WAIT → dmem_req = 0 at once and no wb_valid; after release, a fresh LW, ack at cycle 1 → wb_valid 2 cycles after accept.
- MISALIGN_TRAP_EN defined: LW at 0x101 → no dmem_req, misalign_err pulse, wb_en = 0. Undefined: dmem_addr = 0x100, normal load.
